// File: rtl/sc_statemachine_player_if.sv
// ============================================================================
// sc_statemachine_player_if
// Button inputs and lane/strobe outputs of the player-control state machine.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sc_statemachine_player_if #(
  parameter int POS_WIDTH = 8
);
  logic                 SC_STATEMACHINE_PLAYER_startButton_InLow;
  logic                 SC_STATEMACHINE_PLAYER_leftButton_InLow;
  logic                 SC_STATEMACHINE_PLAYER_rightButton_InLow;
  logic                 SC_STATEMACHINE_PLAYER_enable_InHigh;
  logic                 SC_STATEMACHINE_PLAYER_clear_OutLow;
  logic [1:0]           SC_STATEMACHINE_PLAYER_shiftselection_Out;
  logic                 SC_STATEMACHINE_PLAYER_move_OutHigh;
  logic [POS_WIDTH-1:0] SC_STATEMACHINE_PLAYER_position_Out;
  logic                 SC_STATEMACHINE_PLAYER_atLeft_OutHigh;
  logic                 SC_STATEMACHINE_PLAYER_atRight_OutHigh;

  modport master (
    output SC_STATEMACHINE_PLAYER_startButton_InLow,
    output SC_STATEMACHINE_PLAYER_leftButton_InLow,
    output SC_STATEMACHINE_PLAYER_rightButton_InLow,
    output SC_STATEMACHINE_PLAYER_enable_InHigh,
    input  SC_STATEMACHINE_PLAYER_clear_OutLow,
    input  SC_STATEMACHINE_PLAYER_shiftselection_Out,
    input  SC_STATEMACHINE_PLAYER_move_OutHigh,
    input  SC_STATEMACHINE_PLAYER_position_Out,
    input  SC_STATEMACHINE_PLAYER_atLeft_OutHigh,
    input  SC_STATEMACHINE_PLAYER_atRight_OutHigh
  );

  modport slave (
    input  SC_STATEMACHINE_PLAYER_startButton_InLow,
    input  SC_STATEMACHINE_PLAYER_leftButton_InLow,
    input  SC_STATEMACHINE_PLAYER_rightButton_InLow,
    input  SC_STATEMACHINE_PLAYER_enable_InHigh,
    output SC_STATEMACHINE_PLAYER_clear_OutLow,
    output SC_STATEMACHINE_PLAYER_shiftselection_Out,
    output SC_STATEMACHINE_PLAYER_move_OutHigh,
    output SC_STATEMACHINE_PLAYER_position_Out,
    output SC_STATEMACHINE_PLAYER_atLeft_OutHigh,
    output SC_STATEMACHINE_PLAYER_atRight_OutHigh
  );
endinterface

`default_nettype wire

// File: rtl/sc_statemachine_player.sv
// ============================================================================
// sc_statemachine_player
// Player lane control: button presses to one-hot lane moves with auto-repeat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_statemachine_player #(
  parameter int POS_WIDTH     = 8,
  parameter int INIT_POS      = 3,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                   SC_STATEMACHINE_PLAYER_CLOCK_50,
  input  logic                   SC_STATEMACHINE_PLAYER_RESET_InLow,
  sc_statemachine_player_if.slave bus
);

  localparam int C_CNT_MAXVAL = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_CW         = $clog2(C_CNT_MAXVAL + 1);

  localparam logic [C_CW-1:0]      C_DELAY    = C_CW'(REPEAT_DELAY);
  localparam logic [C_CW-1:0]      C_PERIOD   = C_CW'(REPEAT_PERIOD);
  localparam logic [C_CW-1:0]      C_CNT_SAT  = {C_CW{1'b1}};
  localparam logic [POS_WIDTH-1:0] C_INIT_POS = {{(POS_WIDTH-1){1'b0}}, 1'b1} << INIT_POS;

  typedef enum logic [2:0] {
    S_RESET        = 3'd0,
    S_START        = 3'd1,
    S_IDLE         = 3'd2,
    S_INIT         = 3'd3,
    S_LEFT         = 3'd4,
    S_RIGHT        = 3'd5,
    S_HOLD         = 3'd6,
    S_WAIT_RELEASE = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [POS_WIDTH-1:0]  r_position;
  logic [C_CW-1:0]       r_cnt;
  logic                  r_period_phase;
  logic                  r_dir_left;

  logic       w_start, w_left_raw, w_right_raw, w_en, w_left, w_right;
  logic       w_released, w_at_left, w_at_right, w_expired, w_opposite;
  logic [C_CW-1:0] w_thr;
  logic       w_clear_n, w_move;
  logic [1:0] w_shift;

  assign w_start     = ~bus.SC_STATEMACHINE_PLAYER_startButton_InLow;
  assign w_left_raw  = ~bus.SC_STATEMACHINE_PLAYER_leftButton_InLow;
  assign w_right_raw = ~bus.SC_STATEMACHINE_PLAYER_rightButton_InLow;
  assign w_en        = bus.SC_STATEMACHINE_PLAYER_enable_InHigh;
  assign w_left      = w_left_raw & w_en;
  assign w_right     = w_right_raw & w_en;
  assign w_released  = ~w_start & ~w_left_raw & ~w_right_raw;
  assign w_at_left   = r_position[POS_WIDTH-1];
  assign w_at_right  = r_position[0];
  assign w_thr       = r_period_phase ? C_PERIOD : C_DELAY;
  assign w_expired   = (r_cnt >= w_thr);
  assign w_opposite  = r_dir_left ? w_right_raw : w_left_raw;

  always_comb begin
    w_next    = r_state;
    w_clear_n = 1'b1;
    w_shift   = 2'b11;
    w_move    = 1'b0;
    case (r_state)
      S_RESET: w_next = S_START;
      S_START: w_next = S_IDLE;
      S_IDLE: begin
        if (w_start)                      w_next = S_INIT;
        else if (w_left && w_right)       w_next = S_WAIT_RELEASE;
        else if (w_left && !w_at_left)    w_next = S_LEFT;
        else if (w_right && !w_at_right)  w_next = S_RIGHT;
        else if (w_left || w_right)       w_next = S_WAIT_RELEASE;
      end
      S_INIT: begin
        w_clear_n = 1'b0;
        w_next    = S_WAIT_RELEASE;
      end
      S_LEFT: begin
        w_shift = 2'b01;
        w_move  = 1'b1;
        w_next  = S_HOLD;
      end
      S_RIGHT: begin
        w_shift = 2'b10;
        w_move  = 1'b1;
        w_next  = S_HOLD;
      end
      S_HOLD: begin
        if (w_released)
          w_next = S_IDLE;
        else if (w_start || w_opposite || !w_en)
          w_next = S_WAIT_RELEASE;
        else if ((REPEAT_DELAY != 0) && w_expired) begin
          // At an edge the threshold still expires, but the counter just restarts
          if (r_dir_left && !w_at_left)        w_next = S_LEFT;
          else if (!r_dir_left && !w_at_right) w_next = S_RIGHT;
        end
      end
      S_WAIT_RELEASE: if (w_released) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_STATEMACHINE_PLAYER_CLOCK_50 or negedge SC_STATEMACHINE_PLAYER_RESET_InLow) begin
    if (!SC_STATEMACHINE_PLAYER_RESET_InLow) begin
      r_state        <= S_RESET;
      r_position     <= C_INIT_POS;
      r_cnt          <= '0;
      r_period_phase <= 1'b0;
      r_dir_left     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: r_period_phase <= 1'b0;
        S_INIT: r_position <= C_INIT_POS;
        S_LEFT: begin
          if (!w_at_left) r_position <= {r_position[POS_WIDTH-2:0], 1'b0};
          r_dir_left <= 1'b1;
          r_cnt      <= '0;
        end
        S_RIGHT: begin
          if (!w_at_right) r_position <= {1'b0, r_position[POS_WIDTH-1:1]};
          r_dir_left <= 1'b0;
          r_cnt      <= '0;
        end
        S_HOLD: begin
          if (w_expired)             r_cnt <= '0;
          else if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + C_CW'(1);
          if (w_next == S_LEFT || w_next == S_RIGHT) r_period_phase <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.SC_STATEMACHINE_PLAYER_clear_OutLow       = w_clear_n;
  assign bus.SC_STATEMACHINE_PLAYER_shiftselection_Out = w_shift;
  assign bus.SC_STATEMACHINE_PLAYER_move_OutHigh       = w_move;
  assign bus.SC_STATEMACHINE_PLAYER_position_Out       = r_position;
  assign bus.SC_STATEMACHINE_PLAYER_atLeft_OutHigh     = w_at_left;
  assign bus.SC_STATEMACHINE_PLAYER_atRight_OutHigh    = w_at_right;

endmodule

`default_nettype wire

// File: tb/tb_sc_statemachine_player.sv
// ============================================================================
// tb_sc_statemachine_player
// Directed vector table plus hand sequences for repeat timing, edges and reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sc_statemachine_player;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  sc_statemachine_player_if #(.POS_WIDTH(8)) bus ();

  sc_statemachine_player #(
    .POS_WIDTH(8), .INIT_POS(3), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .SC_STATEMACHINE_PLAYER_CLOCK_50    (clk),
    .SC_STATEMACHINE_PLAYER_RESET_InLow (rst_n),
    .bus                                (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, l, r, en;
    logic [7:0] pos;
    logic       mv;
    logic [1:0] sh;
    logic       clr;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic l, input logic r, input logic en);
    bus.SC_STATEMACHINE_PLAYER_startButton_InLow = st;
    bus.SC_STATEMACHINE_PLAYER_leftButton_InLow  = l;
    bus.SC_STATEMACHINE_PLAYER_rightButton_InLow = r;
    bus.SC_STATEMACHINE_PLAYER_enable_InHigh     = en;
  endtask

  task automatic step(input logic st, input logic l, input logic r, input logic en);
    drive(st, l, r, en);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] pos, input logic mv,
                         input logic [1:0] sh, input logic clr);
    chk({tag, " pos"},   32'(bus.SC_STATEMACHINE_PLAYER_position_Out), 32'(pos));
    chk({tag, " move"},  32'(bus.SC_STATEMACHINE_PLAYER_move_OutHigh), 32'(mv));
    chk({tag, " shift"}, 32'(bus.SC_STATEMACHINE_PLAYER_shiftselection_Out), 32'(sh));
    chk({tag, " clear"}, 32'(bus.SC_STATEMACHINE_PLAYER_clear_OutLow), 32'(clr));
  endtask

  task automatic set_vec(input int i, input logic st, input logic l, input logic r, input logic en,
                         input logic [7:0] pos, input logic mv, input logic [1:0] sh, input logic clr);
    vecs[i].st = st; vecs[i].l = l; vecs[i].r = r; vecs[i].en = en;
    vecs[i].pos = pos; vecs[i].mv = mv; vecs[i].sh = sh; vecs[i].clr = clr;
  endtask

  initial begin
    int pulses[8];
    int np;
    n_chk  = 0;
    n_pass = 0;

    // buttons are raw active-low levels; expected outputs seen after the edge
    set_vec( 0, 1,1,1,1, 8'h08, 0, 2'b11, 1);  // RESET -> START
    set_vec( 1, 1,1,1,1, 8'h08, 0, 2'b11, 1);  // START -> IDLE
    set_vec( 2, 1,0,1,1, 8'h08, 1, 2'b01, 1);  // tap left: LEFT
    set_vec( 3, 1,0,1,1, 8'h10, 0, 2'b11, 1);
    set_vec( 4, 1,0,1,1, 8'h10, 0, 2'b11, 1);
    set_vec( 5, 1,1,1,1, 8'h10, 0, 2'b11, 1);  // released -> IDLE
    set_vec( 6, 0,1,1,1, 8'h10, 0, 2'b11, 0);  // start -> INIT
    set_vec( 7, 1,1,1,1, 8'h08, 0, 2'b11, 1);
    set_vec( 8, 1,1,1,1, 8'h08, 0, 2'b11, 1);
    set_vec( 9, 1,0,1,0, 8'h08, 0, 2'b11, 1);  // enable low: left ignored
    set_vec(10, 1,0,1,0, 8'h08, 0, 2'b11, 1);
    set_vec(11, 1,1,1,1, 8'h08, 0, 2'b11, 1);
    set_vec(12, 1,0,0,1, 8'h08, 0, 2'b11, 1);  // both -> WAIT_RELEASE
    set_vec(13, 1,0,1,1, 8'h08, 0, 2'b11, 1);
    set_vec(14, 1,0,1,1, 8'h08, 0, 2'b11, 1);
    set_vec(15, 1,1,1,1, 8'h08, 0, 2'b11, 1);
    set_vec(16, 1,0,1,1, 8'h08, 1, 2'b01, 1);
    set_vec(17, 1,1,1,1, 8'h10, 0, 2'b11, 1);
    set_vec(18, 1,1,1,1, 8'h10, 0, 2'b11, 1);
    set_vec(19, 1,1,0,1, 8'h10, 1, 2'b10, 1);
    set_vec(20, 1,1,0,1, 8'h08, 0, 2'b11, 1);
    set_vec(21, 0,1,0,1, 8'h08, 0, 2'b11, 1);  // start during HOLD: no clear
    set_vec(22, 1,1,0,1, 8'h08, 0, 2'b11, 1);
    set_vec(23, 1,1,1,1, 8'h08, 0, 2'b11, 1);
    set_vec(24, 1,1,1,1, 8'h08, 0, 2'b11, 1);

    rst_n = 1'b0;
    drive(1, 1, 1, 1);
    #12;
    chk_out("reset", 8'h08, 0, 2'b11, 1);
    chk("reset atLeft",  32'(bus.SC_STATEMACHINE_PLAYER_atLeft_OutHigh), 32'd0);
    chk("reset atRight", 32'(bus.SC_STATEMACHINE_PLAYER_atRight_OutHigh), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].st, vecs[i].l, vecs[i].r, vecs[i].en);
      chk_out($sformatf("vec%0d", i), vecs[i].pos, vecs[i].mv, vecs[i].sh, vecs[i].clr);
    end

    // hold right from 0x08: pulses at t, t+6, t+10 then parked at the edge
    np = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 1, 0, 1);
      if (bus.SC_STATEMACHINE_PLAYER_move_OutHigh === 1'b1) begin
        chk("holdR shift", 32'(bus.SC_STATEMACHINE_PLAYER_shiftselection_Out), 32'h2);
        if (np < 8) pulses[np] = i;
        np++;
      end
    end
    chk("holdR pulses", 32'(np), 32'd3);
    chk("holdR first", 32'(pulses[0]), 32'd0);
    chk("holdR gap1", 32'(pulses[1] - pulses[0]), 32'd6);
    chk("holdR gap2", 32'(pulses[2] - pulses[1]), 32'd4);
    chk("holdR pos", 32'(bus.SC_STATEMACHINE_PLAYER_position_Out), 32'h01);
    chk("holdR atRight", 32'(bus.SC_STATEMACHINE_PLAYER_atRight_OutHigh), 32'd1);
    step(1, 1, 1, 1);
    step(1, 0, 1, 1);
    chk_out("after holdR left", 8'h01, 1, 2'b01, 1);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    chk("pos 02", 32'(bus.SC_STATEMACHINE_PLAYER_position_Out), 32'h02);

    // start from IDLE at 0x02: one-cycle clear, reload to 0x08
    step(0, 1, 1, 1);
    chk_out("start idle", 8'h02, 0, 2'b11, 0);
    step(1, 1, 1, 1);
    chk_out("start reload", 8'h08, 0, 2'b11, 1);
    step(1, 1, 1, 1);

    // hold left up to the MSB edge
    np = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 1, 1);
      if (bus.SC_STATEMACHINE_PLAYER_move_OutHigh === 1'b1) np++;
    end
    chk("holdL pulses", 32'(np), 32'd4);
    chk("holdL pos", 32'(bus.SC_STATEMACHINE_PLAYER_position_Out), 32'h80);
    chk("holdL atLeft", 32'(bus.SC_STATEMACHINE_PLAYER_atLeft_OutHigh), 32'd1);
    step(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 1);
      chk_out($sformatf("edgeL%0d", i), 8'h80, 0, 2'b11, 1);
    end
    step(1, 1, 1, 1);

    // move right to 0x20 and sit in HOLD, then reset mid-hold
    step(1, 1, 0, 1);
    chk_out("right from edge", 8'h80, 1, 2'b10, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
    chk_out("hold at 20", 8'h20, 0, 2'b11, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 8'h08, 0, 2'b11, 1);
    drive(1, 0, 1, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst edge1 move", 32'(bus.SC_STATEMACHINE_PLAYER_move_OutHigh), 32'd0);
    @(posedge clk); #1;
    chk("post-rst edge2 move", 32'(bus.SC_STATEMACHINE_PLAYER_move_OutHigh), 32'd0);
    @(posedge clk); #1;
    chk_out("post-rst edge3", 8'h08, 1, 2'b01, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
